layer_sequencer: RTL
====================

# layer_sequencer

Time-multiplexed controller for one fully-connected layer. It reuses a single serial multiply-accumulate datapath for every neuron in the layer and follows the same fixed-point rules as the parallel neuron: signed 8-bit operands, full-width products, an unshifted bias add and saturation to the 8-bit range. It sits between the input-activation buffer, the weight ROM and bias ROM, and the output-activation buffer. It issues all read addresses, sequences the accumulation and writes one saturated result per neuron.

## Interface
- RESOLUTION, 8: operand and result width in bits (signed).
- NUM_INPUTS, 16: inputs per neuron (fan-in); must be ≥ 2.
- NUM_NEURONS, 10: neurons in the layer.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state and outputs immediately.
- start  in  1  pulse that begins a layer pass; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE with no further writes and no done.
- busy  out  1  high in every state except IDLE; reset 0.
- done  out  1  one-cycle pulse after the last write; reset 0.
- in_addr  out  clog2(NUM_INPUTS)  input-buffer read address; reset 0.
- in_data  in  RESOLUTION  signed activation, valid 1 cycle after in_addr.
- w_addr  out  clog2(NUM_INPUTS*NUM_NEURONS)  weight ROM address = neuron*NUM_INPUTS + i; reset 0.
- w_data  in  RESOLUTION  signed weight, valid 1 cycle after w_addr.
- b_addr  out  clog2(NUM_NEURONS)  bias ROM address = current neuron index, held for the whole neuron; reset 0.
- b_data  in  RESOLUTION  signed bias, stable by the BIAS state.
- out_we  out  1  one-cycle write strobe; reset 0.
- out_addr  out  clog2(NUM_NEURONS)  neuron index being written; reset 0.
- out_data  out  RESOLUTION  saturated neuron result; reset 0.

## Operation
- FSM states: IDLE, MAC, BIAS, WRITE, DONE.
- IDLE:
  - Accumulator, input counter and neuron counter are held at 0.
  - When start=1, go to MAC.
- MAC lasts NUM_INPUTS+1 cycles.
  - In MAC cycle j (0..NUM_INPUTS-1), issue in_addr=j and w_addr=n*NUM_INPUTS+j.
  - In MAC cycles 1..NUM_INPUTS, add the product in_data*w_data to the accumulator.
  - The accumulator is cleared on entry to MAC.
- BIAS lasts 1 cycle.
  - z = acc + sign-extended b_data. The bias is not shifted.
  - Saturate: z>127 gives 127, z<-128 gives -128, otherwise z[RESOLUTION-1:0].
  - Register the result into out_data.
- WRITE lasts 1 cycle.
  - out_we=1, out_addr=n, out_data is the saturated value.
  - If n=NUM_NEURONS-1, go to DONE; otherwise increment n and go to MAC.
- DONE lasts 1 cycle: done=1, then go to IDLE.
- Widths:
  - Product: 2*RESOLUTION bits, signed.
  - Accumulator: 2*RESOLUTION+clog2(NUM_INPUTS)+1 bits, signed. It never wraps for any legal inputs.
- Boundary conditions:
  - start outside IDLE is ignored. Back-to-back passes are allowed only after the DONE→IDLE cycle.
  - abort in any non-IDLE state goes to IDLE on the next edge. out_we is forced to 0 in the abort cycle, even in WRITE. No done is produced.
  - abort and start high together in IDLE: abort wins and the block stays in IDLE.
  - reset asserted mid-pass clears everything asynchronously, including an in-flight out_we.
  - out_data holds its last written value between writes.

## Timing
- Count cycles from the edge that samples start in IDLE as edge 0.
- Cycles per neuron: NUM_INPUTS+3.
- Neuron k's out_we is asserted in cycle (k+1)*(NUM_INPUTS+3).
- done is asserted in cycle NUM_NEURONS*(NUM_INPUTS+3)+1.
- busy rises in cycle 1 and falls in the cycle after done.
- Read latency is fixed at 1 cycle; there is no stall/ready path. Memories must meet this latency.

## Configuration
- LAYER_SEQ_RELU_EN defined: after saturation, negative results are replaced by 0, so out_data is in 0..127.
- LAYER_SEQ_RELU_EN undefined: the signed saturated value is written unchanged, in -128..127.
- Timing is identical in both builds.

## Test plan
All scenarios use NUM_INPUTS=4 and NUM_NEURONS=2.
- All in_data=10, all w_data=3, b_data=5 → out_data=125 with out_we in cycles 7 and 14, out_addr 0 then 1; done in cycle 15.
- in_data=127, w_data=127, bias 0 → out_data=127 (saturated high), for both neurons.
- in_data=127, w_data=-128, b_data=-1 → -128 without RELU; 0 with LAYER_SEQ_RELU_EN.
- Mixed case: weights {1,-1,2,-2} on inputs {4,4,3,3}, bias -2 → -2 without RELU, 0 with RELU. Also check the w_addr sequence is 0..3 then 4..7.
- abort in cycle 9 → out_we is never asserted for neuron 1, no done, busy=0 from cycle 10. A new start then produces a full correct pass.
- Pull reset low in cycle 7 (the WRITE cycle) → out_we, busy and out_data go to 0 immediately. Release reset and pulse start → normal results.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: serial MAC controller for one fully-connected layer.
// Reuses one multiply-accumulate path for every neuron, adds an unshifted
// bias, saturates to RESOLUTION bits and writes one result per neuron.
// Build option: define LAYER_SEQ_RELU_EN to clamp negative results to 0.
//
// state | meaning
// IDLE  | counters and accumulator held at 0, waiting for start
// MAC   | NUM_INPUTS+1 cycles: issue reads, accumulate products one cycle later
// BIAS  | add bias, saturate, register into out_data
// WRITE | out_we strobe for the current neuron
// DONE  | one-cycle done pulse
module layer_sequencer #(
  parameter int RESOLUTION  = 8,
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 10
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         abort,
  output logic                                         busy,
  output logic                                         done,
  output logic [$clog2(NUM_INPUTS)-1:0]                in_addr,
  input  logic [RESOLUTION-1:0]                        in_data,
  output logic [$clog2(NUM_INPUTS*NUM_NEURONS)-1:0]    w_addr,
  input  logic [RESOLUTION-1:0]                        w_data,
  output logic [$clog2(NUM_NEURONS)-1:0]               b_addr,
  input  logic [RESOLUTION-1:0]                        b_data,
  output logic                                         out_we,
  output logic [$clog2(NUM_NEURONS)-1:0]               out_addr,
  output logic [RESOLUTION-1:0]                        out_data
);

  localparam int IW = $clog2(NUM_INPUTS);
  localparam int WW = $clog2(NUM_INPUTS*NUM_NEURONS);
  localparam int NW = $clog2(NUM_NEURONS);
  localparam int CW = $clog2(NUM_INPUTS+1);
  localparam int PW = 2*RESOLUTION;
  localparam int AW = 2*RESOLUTION + $clog2(NUM_INPUTS) + 1;
  localparam int ZW = AW + 1;

  localparam logic signed [ZW-1:0] Z_MAX = ZW'((1 << (RESOLUTION-1)) - 1);
  localparam logic signed [ZW-1:0] Z_MIN = ~Z_MAX;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MAC   = 3'd1,
    S_BIAS  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]         i_cnt;
  logic [NW-1:0]         n_cnt;
  logic [WW-1:0]         w_base;
  logic signed [AW-1:0]  acc;
  logic signed [PW-1:0]  prod;
  logic signed [ZW-1:0]  z;
  logic [RESOLUTION-1:0] sat_val;
  logic                  mac_last;
  logic                  neuron_last;

  assign mac_last    = (i_cnt == CW'(NUM_INPUTS));
  assign neuron_last = (n_cnt == NW'(NUM_NEURONS-1));

  // In the final MAC cycle no new read is needed; clamp to stay in range.
  assign in_addr  = mac_last ? IW'(NUM_INPUTS-1) : i_cnt[IW-1:0];
  assign w_addr   = w_base + WW'(in_addr);
  assign b_addr   = n_cnt;
  assign out_addr = n_cnt;

  assign prod = PW'($signed(in_data)) * PW'($signed(w_data));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state and strobe outputs; abort overrides every non-IDLE state.
  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    out_we     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) state_next = S_MAC;
      end
      S_MAC: begin
        if (abort)         state_next = S_IDLE;
        else if (mac_last) state_next = S_BIAS;
      end
      S_BIAS: begin
        state_next = abort ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        out_we = !abort;
        if (abort)            state_next = S_IDLE;
        else if (neuron_last) state_next = S_DONE;
        else                  state_next = S_MAC;
      end
      S_DONE: begin
        done       = !abort;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Counters and accumulator; everything returns to 0 whenever IDLE is next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      i_cnt  <= '0;
      n_cnt  <= '0;
      w_base <= '0;
    end else if (state_next == S_IDLE) begin
      acc    <= '0;
      i_cnt  <= '0;
      n_cnt  <= '0;
      w_base <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          acc   <= '0;
          i_cnt <= '0;
        end
        S_MAC: begin
          if (i_cnt != '0) acc <= acc + {{(AW-PW){prod[PW-1]}}, prod};
          i_cnt <= (state_next == S_MAC) ? i_cnt + CW'(1) : '0;
        end
        S_WRITE: begin
          acc   <= '0;
          i_cnt <= '0;
          if (state_next == S_MAC) begin
            n_cnt  <= n_cnt + NW'(1);
            w_base <= w_base + WW'(NUM_INPUTS);
          end
        end
        default: ;
      endcase
    end
  end

  // Bias add, saturation and optional ReLU on the finished accumulator.
  always_comb begin
    z = {acc[AW-1], acc} + {{(ZW-RESOLUTION){b_data[RESOLUTION-1]}}, b_data};
    if (z > Z_MAX)      sat_val = {1'b0, {(RESOLUTION-1){1'b1}}};
    else if (z < Z_MIN) sat_val = {1'b1, {(RESOLUTION-1){1'b0}}};
    else                sat_val = z[RESOLUTION-1:0];
`ifdef LAYER_SEQ_RELU_EN
    if (sat_val[RESOLUTION-1]) sat_val = '0;
`else
    sat_val = sat_val;
`endif
  end

  // Result register: loaded in BIAS, holds its value between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        out_data <= '0;
    else if (state == S_BIAS && !abort) out_data <= sat_val;
  end

endmodule
